// File: rtl/divisor_por_2.sv
// divisor_por_2
// Registered halving of an unsigned sync counter value. It turns an 11-bit pixel/line
// count into a 10-bit half-resolution index for the memory/pixel address logic.
// The discarded LSB and a valid strobe are registered alongside the result.
//
// Ports
//   clk_i           system clock, rising edge
//   reset_i         asynchronous, active-high reset
//   en_i            sample enable; when low, cuenta_o and resto_o hold
//   incont_i        unsigned counter value to halve (IN_W bits)
//   cuenta_o        registered incont_i/2 (floor, or round-half-up when ROUND=1)
//   resto_o         registered LSB of the sampled incont_i
//   cuenta_valid_o  high for the cycle after an enabled sample
module divisor_por_2 #(
    parameter int IN_W  = 11,
    parameter int OUT_W = 10,
    parameter int ROUND = 0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic [IN_W-1:0]  incont_i,
    output logic [OUT_W-1:0] cuenta_o,
    output logic             resto_o,
    output logic             cuenta_valid_o
);

    if (OUT_W != IN_W - 1) begin : g_width_check
        $error("divisor_por_2: OUT_W must equal IN_W-1");
    end

    logic [OUT_W-1:0] half_w;

    if (ROUND == 0) begin : g_floor
        assign half_w = incont_i[IN_W-1:1];
    end else begin : g_round
        // (x+1)>>1 is the same as (x>>1) + x[0]; the one extra carry bit flags the
        // single input (all ones) whose rounded half no longer fits in OUT_W bits.
        logic [OUT_W:0] sum_w;
        assign sum_w  = {1'b0, incont_i[IN_W-1:1]} + {{OUT_W{1'b0}}, incont_i[0]};
        assign half_w = sum_w[OUT_W] ? {OUT_W{1'b1}} : sum_w[OUT_W-1:0];
    end

    logic [OUT_W-1:0] cuenta_q, cuenta_d;
    logic             resto_q, resto_d;
    logic             valid_q, valid_d;

    // The hold path is chosen by en_i alone, so an unknown incont_i while disabled
    // never reaches the registers.
    always_comb begin
        cuenta_d = cuenta_q;
        resto_d  = resto_q;
        valid_d  = 1'b0;
        if (en_i) begin
            cuenta_d = half_w;
            resto_d  = incont_i[0];
            valid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cuenta_q <= '0;
            resto_q  <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            cuenta_q <= cuenta_d;
            resto_q  <= resto_d;
            valid_q  <= valid_d;
        end
    end

    assign cuenta_o       = cuenta_q;
    assign resto_o        = resto_q;
    assign cuenta_valid_o = valid_q;

endmodule

// File: tb/tb_divisor_por_2.sv
// Bench for divisor_por_2: a floor instance and a rounding instance share the same
// stimulus; an arithmetic model is compared every falling edge, and directed checks
// pin literal values from hand calculation.
module tb_divisor_por_2;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [10:0] incont;

    logic [9:0]  f_cuenta, r_cuenta;
    logic        f_resto, r_resto, f_valid, r_valid;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    int m_cuenta = 0;
    int m_cround = 0;
    int m_resto  = 0;
    int m_valid  = 0;

    always #5 clk = ~clk;

    divisor_por_2 #(.IN_W(11), .OUT_W(10), .ROUND(0)) u_floor (
        .clk_i          (clk),
        .reset_i        (reset),
        .en_i           (en),
        .incont_i       (incont),
        .cuenta_o       (f_cuenta),
        .resto_o        (f_resto),
        .cuenta_valid_o (f_valid)
    );

    divisor_por_2 #(.IN_W(11), .OUT_W(10), .ROUND(1)) u_round (
        .clk_i          (clk),
        .reset_i        (reset),
        .en_i           (en),
        .incont_i       (incont),
        .cuenta_o       (r_cuenta),
        .resto_o        (r_resto),
        .cuenta_valid_o (r_valid)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: plain integer division of the sampled value.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cuenta <= 0;
            m_cround <= 0;
            m_resto  <= 0;
            m_valid  <= 0;
        end else begin
            m_valid <= (en === 1'b1) ? 1 : 0;
            if (en === 1'b1) begin
                m_cuenta <= int'(incont) / 2;
                m_cround <= ((int'(incont) + 1) / 2 > 1023) ? 1023 : (int'(incont) + 1) / 2;
                m_resto  <= int'(incont) % 2;
            end
        end
    end

    always @(negedge clk) begin
        chk("floor_cuenta", 32'(f_cuenta), 32'(m_cuenta));
        chk("floor_resto",  32'(f_resto),  32'(m_resto));
        chk("floor_valid",  32'(f_valid),  32'(m_valid));
        chk("round_cuenta", 32'(r_cuenta), 32'(m_cround));
        chk("round_resto",  32'(r_resto),  32'(m_resto));
        chk("round_valid",  32'(r_valid),  32'(m_valid));
    end

    task automatic drive(input logic e, input logic [10:0] x);
        en     = e;
        incont = x;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset  = 1'b1;
        en     = 1'b0;
        incont = '0;
        #2;
        chk("reset_cuenta", 32'(f_cuenta), 0);
        chk("reset_resto",  32'(f_resto),  0);
        chk("reset_valid",  32'(f_valid),  0);
        @(posedge clk);
        #1 reset = 1'b0;

        drive(1'b1, 11'd4);
        chk("t1_cuenta", 32'(f_cuenta), 2);
        chk("t1_resto",  32'(f_resto),  0);
        chk("t1_valid",  32'(f_valid),  1);

        drive(1'b1, 11'd8);
        chk("t2_cuenta8", 32'(f_cuenta), 4);
        drive(1'b1, 11'd5);
        chk("t2_cuenta5", 32'(f_cuenta), 2);
        chk("t2_resto5",  32'(f_resto),  1);
        chk("t3_round5",  32'(r_cuenta), 3);

        drive(1'b1, 11'd0);
        chk("t3_zero", 32'(f_cuenta), 0);
        drive(1'b1, 11'd2047);
        chk("t3_max_floor", 32'(f_cuenta), 1023);
        chk("t3_max_resto", 32'(f_resto),  1);
        chk("t3_max_round", 32'(r_cuenta), 1023);
        chk("t3_max_rresto", 32'(r_resto), 1);

        drive(1'b1, 11'd6);
        drive(1'b0, 11'd10);
        chk("t4_hold_a", 32'(f_cuenta), 3);
        chk("t4_valid0", 32'(f_valid),  0);
        drive(1'b0, 11'd600);
        chk("t4_hold_b", 32'(f_cuenta), 3);
        drive(1'b0, 11'bx);
        chk("t4_x_blocked", 32'($isunknown({f_cuenta, f_resto, r_cuenta, r_resto})), 0);
        drive(1'b1, 11'd600);
        chk("t4_cuenta300", 32'(f_cuenta), 300);
        chk("t4_valid1",    32'(f_valid),  1);

        // asynchronous reset between edges
        en = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("t5_async_cuenta", 32'(f_cuenta), 0);
        chk("t5_async_valid",  32'(f_valid),  0);
        chk("t5_async_round",  32'(r_cuenta), 0);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        drive(1'b1, 11'd101);
        chk("t5_after_release", 32'(f_cuenta), 50);
        chk("t5_after_resto",   32'(f_resto),  1);
        chk("t5_after_valid",   32'(f_valid),  1);

        // reset raised at a clock edge while sampling
        en     = 1'b1;
        incont = 11'd900;
        @(posedge clk);
        reset = 1'b1;
        #1;
        chk("t5_edge_cuenta", 32'(f_cuenta), 0);
        chk("t5_edge_valid",  32'(f_valid),  0);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 1000; i++) begin
            drive(($urandom_range(0, 3) != 0), 11'($urandom_range(0, 2047)));
        end
        drive(1'b0, 11'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
